// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and the serializer state encoding.
package mmio_uart_tx_pkg;

    localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0004;

    localparam int STATUS_EMPTY_BIT  = 0;
    localparam int STATUS_FULL_BIT   = 1;
    localparam int STATUS_BUSY_BIT   = 2;
    localparam int STATUS_IRQEN_BIT  = 3;
    localparam int STATUS_OVF_BIT    = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock transmit FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle. Head entry is visible combinationally on rdata_o.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset so it can map onto plain RAM resources.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS reports
// and controls the block, and a baud-timed serializer drains the FIFO.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0024,
    parameter int          BAUD_DIV   = 5208,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        uart_tx,
    output logic        irq
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        irq_en_q, irq_en_d;
    logic        ovf_q, ovf_d;
    logic        irq_q, irq_d;

    logic        txdata_sel, status_sel;
    logic        txdata_wr, status_wr;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        tx_busy;
    logic [31:0] status_word;

    assign txdata_sel = (addr == BASE_ADDR + TXDATA_OFF);
    assign status_sel = (addr == BASE_ADDR + STATUS_OFF);
    assign hit        = txdata_sel || status_sel;
    assign txdata_wr  = wr && txdata_sel;
    assign status_wr  = wr && status_sel;
    assign tx_busy    = (state_q != TX_IDLE);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (txdata_wr),
        .pop_i   (fifo_pop),
        .wdata_i (wdata[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_BUSY_BIT]  = tx_busy;
        status_word[STATUS_IRQEN_BIT] = irq_en_q;
        status_word[STATUS_OVF_BIT]   = ovf_q;
    end

    assign rdata = (rd && status_sel) ? status_word : 32'h0;

    // A dropped push takes priority over a clear arriving in the same cycle.
    always_comb begin
        irq_en_d = status_wr ? wdata[STATUS_IRQEN_BIT] : irq_en_q;
        ovf_d    = ovf_q;
        if (status_wr && wdata[STATUS_OVF_BIT]) ovf_d = 1'b0;
        if (txdata_wr && fifo_full && !fifo_pop) ovf_d = 1'b1;
        irq_d    = irq_en_q && fifo_empty && !tx_busy;
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    tx_d     = 1'b0;
                    baud_d   = BAUD_RELOAD;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (baud_q == 16'd0) begin
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = TX_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (baud_q == 16'd0) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tx_d     = 1'b0;
                        baud_d   = BAUD_RELOAD;
                        state_d  = TX_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
        end
    end

    assign uart_tx = tx_q;
    assign irq     = irq_q;

endmodule
